// File: rtl/simple_risc_pipe.sv
// SimpleRISC 32-bit, 5-stage in-order pipeline (IF, OF, EX, MA, RW) with internal
// instruction memory, data memory and register file. No interlocks or forwarding.
module simple_risc_pipe #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic reset
);
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
        OP_MOD  = 5'd4,  OP_CMP  = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7,
        OP_NOT  = 5'd8,  OP_MOV  = 5'd9,  OP_LSL  = 5'd10, OP_LSR  = 5'd11,
        OP_ASR  = 5'd12, OP_NOP  = 5'd13, OP_LD   = 5'd14, OP_ST   = 5'd15,
        OP_BEQ  = 5'd16, OP_BGT  = 5'd17, OP_B    = 5'd18, OP_CALL = 5'd19,
        OP_RET  = 5'd20
    } opcode_t;

    localparam logic [31:0] NOP = 32'h6800_0000;
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    // Instruction memory is loaded externally; it powers up full of nops.
    logic [31:0] Instruction_MEM [IMEM_DEPTH] = '{default: NOP};
    logic [31:0] r_dmem [DMEM_DEPTH];
    logic [31:0] r [16];
    logic [31:0] pc;
    logic        flag_E;
    logic        flag_GT;

    logic [31:0] r_of_ir, r_of_pc;
    logic [31:0] r_ex_ir, r_ex_pc, r_ex_a, r_ex_b, r_ex_sv, r_ex_ra;
    opcode_t     r_ma_op;
    logic        r_ma_we;
    logic [3:0]  r_ma_rd;
    logic [31:0] r_ma_alu, r_ma_sv;
    logic        r_rw_we;
    logic [3:0]  r_rw_rd;
    logic [31:0] r_rw_res;

    function automatic logic [31:0] wrap_pc(input logic [31:0] x);
        return x % 32'(IMEM_DEPTH);
    endfunction

    // ---------------- OF: decode and register read ----------------
    opcode_t     w_of_op;
    logic [31:0] w_of_imm;
    logic [31:0] w_of_b;

    assign w_of_op = opcode_t'(r_of_ir[31:27]);

    always_comb begin
        case (r_of_ir[17:16])
            2'b00:   w_of_imm = {{16{r_of_ir[15]}}, r_of_ir[15:0]};
            2'b01:   w_of_imm = {16'h0000, r_of_ir[15:0]};
            default: w_of_imm = {r_of_ir[15:0], 16'h0000};
        endcase
    end

    // Loads and stores always address with rs1 + imm, whatever the I bit says.
    assign w_of_b = (r_of_ir[26] || w_of_op == OP_LD || w_of_op == OP_ST)
                    ? w_of_imm : r[r_of_ir[17:14]];

    // ---------------- EX: ALU, flags, branch resolution ----------------
    opcode_t     w_ex_op;
    logic [31:0] w_alu;
    logic        w_ex_we;
    logic [3:0]  w_ex_rd;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_taken;
    logic [31:0] w_target;

    assign w_ex_op    = opcode_t'(r_ex_ir[31:27]);
    assign w_div_zero = (r_ex_b == 32'h0);
    assign w_div_ovf  = (r_ex_a == 32'h8000_0000) && (r_ex_b == 32'hFFFF_FFFF);
    assign w_ex_rd    = (w_ex_op == OP_CALL) ? 4'd15 : r_ex_ir[25:22];

    always_comb begin
        w_alu   = 32'h0;
        w_ex_we = 1'b0;
        case (w_ex_op)
            OP_ADD:  begin w_alu = r_ex_a + r_ex_b;  w_ex_we = 1'b1; end
            OP_SUB:  begin w_alu = r_ex_a - r_ex_b;  w_ex_we = 1'b1; end
            OP_MUL:  begin w_alu = r_ex_a * r_ex_b;  w_ex_we = 1'b1; end
            OP_DIV: begin
                w_ex_we = 1'b1;
                if (w_div_zero)     w_alu = 32'h0;
                else if (w_div_ovf) w_alu = 32'h8000_0000;
                else                w_alu = $signed(r_ex_a) / $signed(r_ex_b);
            end
            OP_MOD: begin
                w_ex_we = 1'b1;
                if (w_div_zero || w_div_ovf) w_alu = 32'h0;
                else                         w_alu = $signed(r_ex_a) % $signed(r_ex_b);
            end
            OP_AND:  begin w_alu = r_ex_a & r_ex_b;  w_ex_we = 1'b1; end
            OP_OR:   begin w_alu = r_ex_a | r_ex_b;  w_ex_we = 1'b1; end
            OP_NOT:  begin w_alu = ~r_ex_b;          w_ex_we = 1'b1; end
            OP_MOV:  begin w_alu = r_ex_b;           w_ex_we = 1'b1; end
            OP_LSL:  begin w_alu = r_ex_a << r_ex_b[4:0]; w_ex_we = 1'b1; end
            OP_LSR:  begin w_alu = r_ex_a >> r_ex_b[4:0]; w_ex_we = 1'b1; end
            OP_ASR:  begin w_alu = $signed(r_ex_a) >>> r_ex_b[4:0]; w_ex_we = 1'b1; end
            OP_LD:   begin w_alu = r_ex_a + r_ex_b;  w_ex_we = 1'b1; end
            OP_ST:   w_alu = r_ex_a + r_ex_b;
            OP_CALL: begin w_alu = r_ex_pc + 32'd1;  w_ex_we = 1'b1; end
            default: begin w_alu = 32'h0;            w_ex_we = 1'b0; end
        endcase
    end

    assign w_taken  = (w_ex_op == OP_B) || (w_ex_op == OP_CALL) || (w_ex_op == OP_RET) ||
                      (w_ex_op == OP_BEQ && flag_E) || (w_ex_op == OP_BGT && flag_GT);
    assign w_target = wrap_pc((w_ex_op == OP_RET) ? r_ex_ra : {5'b0, r_ex_ir[26:0]});

    // ---------------- MA: data memory ----------------
    logic [DAW-1:0] w_ma_idx;
    assign w_ma_idx = DAW'(r_ma_alu % 32'(DMEM_DEPTH));

    always_ff @(posedge clk) begin
        if (reset && r_ma_op == OP_ST)
            r_dmem[w_ma_idx] <= r_ma_sv;
    end

    // ---------------- pipeline latches, flags, register file ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= 32'h0;
            flag_E   <= 1'b0;
            flag_GT  <= 1'b0;
            r_of_ir  <= NOP;
            r_of_pc  <= 32'h0;
            r_ex_ir  <= NOP;
            r_ex_pc  <= 32'h0;
            r_ex_a   <= 32'h0;
            r_ex_b   <= 32'h0;
            r_ex_sv  <= 32'h0;
            r_ex_ra  <= 32'h0;
            r_ma_op  <= OP_NOP;
            r_ma_we  <= 1'b0;
            r_ma_rd  <= 4'h0;
            r_ma_alu <= 32'h0;
            r_ma_sv  <= 32'h0;
            r_rw_we  <= 1'b0;
            r_rw_rd  <= 4'h0;
            r_rw_res <= 32'h0;
            for (int i = 0; i < 16; i++) r[i] <= 32'h0;
        end else begin
            pc      <= w_taken ? w_target : wrap_pc(pc + 32'd1);
            // A taken branch squashes the two younger instructions.
            r_of_ir <= w_taken ? NOP : Instruction_MEM[pc[IAW-1:0]];
            r_of_pc <= pc;
            r_ex_ir <= w_taken ? NOP : r_of_ir;
            r_ex_pc <= r_of_pc;
            r_ex_a  <= r[r_of_ir[21:18]];
            r_ex_b  <= w_of_b;
            r_ex_sv <= r[r_of_ir[25:22]];
            r_ex_ra <= r[15];

            if (w_ex_op == OP_CMP) begin
                flag_E  <= (r_ex_a == r_ex_b);
                flag_GT <= ($signed(r_ex_a) > $signed(r_ex_b));
            end
            r_ma_op  <= w_ex_op;
            r_ma_we  <= w_ex_we;
            r_ma_rd  <= w_ex_rd;
            r_ma_alu <= w_alu;
            r_ma_sv  <= r_ex_sv;

            r_rw_we  <= r_ma_we;
            r_rw_rd  <= r_ma_rd;
            r_rw_res <= (r_ma_op == OP_LD) ? r_dmem[w_ma_idx] : r_ma_alu;

            if (r_rw_we) r[r_rw_rd] <= r_rw_res;
        end
    end
endmodule

// File: tb/tb_simple_risc_pipe.sv
// Directed-program bench for simple_risc_pipe: loads small programs into the
// instruction memory and checks architectural state after a fixed cycle count.
module tb_simple_risc_pipe;
    localparam logic [31:0] NOP = 32'h6800_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    simple_risc_pipe #(.IMEM_DEPTH(256), .DMEM_DEPTH(1024)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.Instruction_MEM[i] = NOP;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.Instruction_MEM[idx] = w;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_run(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("imem_init_nop", dut.Instruction_MEM[200], NOP);

        // Immediates program, also used to confirm reset leaves imem alone
        clear_imem();
        put(0, 32'h4C00_000A);
        put(1, 32'h4C40_0001);
        put(4, 32'h4880_0000);
        hold_reset();
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_flag_E", {31'b0, dut.flag_E}, 32'h0);
        chk("rst_flag_GT", {31'b0, dut.flag_GT}, 32'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), dut.r[i], 32'h0);
        chk("rst_imem0", dut.Instruction_MEM[0], 32'h4C00_000A);
        chk("rst_imem4", dut.Instruction_MEM[4], 32'h4880_0000);
        release_run(12);
        chk("imm_r0", dut.r[0], 32'h0000_000A);
        chk("imm_r1", dut.r[1], 32'h0000_0001);
        chk("imm_r2", dut.r[2], 32'h0000_000A);
        chk("imm_pc", dut.pc, 32'd12);

        // Factorial of 10 via bgt loop, parked on a self-branch at word 18
        clear_imem();
        put(0, 32'h4C00_000A);
        put(1, 32'h4C40_0001);
        put(4, 32'h4880_0000);
        put(8, 32'h1044_8000);
        put(9, 32'h0C88_0001);
        put(13, 32'h2C08_0001);
        put(17, 32'h8800_0005);
        put(18, 32'h9000_0012);
        hold_reset();
        release_run(250);
        chk("fact_r1", dut.r[1], 32'h0037_5F00);
        chk("fact_r2", dut.r[2], 32'h0000_0001);
        chk("fact_r0", dut.r[0], 32'h0000_000A);
        chk("fact_flag_E", {31'b0, dut.flag_E}, 32'h1);
        chk("fact_flag_GT", {31'b0, dut.flag_GT}, 32'h0);
        chk("fact_pc_parked", 32'(dut.pc >= 32'd18 && dut.pc <= 32'd20), 32'h1);

        hold_reset();
        chk("rst2_flag_E", {31'b0, dut.flag_E}, 32'h0);
        chk("rst2_r1", dut.r[1], 32'h0);
        chk("rst2_pc", dut.pc, 32'h0);

        // Branch squash: b 10 shadowed by two increments of r3
        clear_imem();
        put(0, 32'h4CC0_0005);
        put(4, 32'h9000_000A);
        put(5, 32'h04CC_0001);
        put(6, 32'h04CC_0001);
        put(7, 32'h4D80_0077);
        put(10, 32'h4D00_0044);
        put(11, 32'h9000_000B);
        release_run(30);
        chk("br_r3_unchanged", dut.r[3], 32'h0000_0005);
        chk("br_r4_target", dut.r[4], 32'h0000_0044);
        chk("br_r6_skipped", dut.r[6], 32'h0);
        chk("br_pc_parked", 32'(dut.pc >= 32'd11 && dut.pc <= 32'd13), 32'h1);

        // Hazard spacing: distances 1 and 3 read stale r7, distance 4 reads new
        clear_imem();
        put(0, 32'h4DC0_0001);
        put(4, 32'h4DC0_0002);
        put(5, 32'h061C_0000);
        put(7, 32'h065C_0000);
        put(8, 32'h069C_0000);
        hold_reset();
        release_run(20);
        chk("haz_r7", dut.r[7], 32'h0000_0002);
        chk("haz_d1_stale", dut.r[8], 32'h0000_0001);
        chk("haz_d3_stale", dut.r[9], 32'h0000_0001);
        chk("haz_d4_fresh", dut.r[10], 32'h0000_0002);
        chk("haz_no_stall_pc", dut.pc, 32'd20);

        // Store then load, including an address that wraps the data memory
        clear_imem();
        put(0, 32'h4D00_1234);
        put(4, 32'h7D00_0004);
        put(8, 32'h7540_0004);
        put(9, 32'h7580_0404);
        hold_reset();
        release_run(20);
        chk("ldst_r5", dut.r[5], 32'h0000_1234);
        chk("ldst_wrap_r6", dut.r[6], 32'h0000_1234);

        // Signed div/mod, shifts, immediate modes, call/ret, signed cmp
        clear_imem();
        put(0, 32'h4C40_FFF9);
        put(1, 32'h4C80_0002);
        put(5, 32'h18C4_8000);
        put(6, 32'h2104_8000);
        put(7, 32'h1944_0000);
        put(8, 32'h6584_0001);
        put(9, 32'h5DC4_001C);
        put(10, 32'h4E02_ABCD);
        put(11, 32'h4E41_8001);
        put(12, 32'h9800_0014);
        put(13, 32'h4E80_005A);
        put(14, 32'h2808_4000);
        put(15, 32'h9000_000F);
        put(20, 32'h4EC0_0011);
        put(23, 32'hA000_0000);
        put(24, 32'h4F00_0099);
        hold_reset();
        release_run(60);
        chk("alu_div", dut.r[3], 32'hFFFF_FFFD);
        chk("alu_mod", dut.r[4], 32'hFFFF_FFFF);
        chk("alu_div0", dut.r[5], 32'h0);
        chk("alu_asr", dut.r[6], 32'hFFFF_FFFC);
        chk("alu_lsr", dut.r[7], 32'h0000_000F);
        chk("imm_hi", dut.r[8], 32'hABCD_0000);
        chk("imm_zext", dut.r[9], 32'h0000_8001);
        chk("call_link_r15", dut.r[15], 32'h0000_000D);
        chk("call_body_r11", dut.r[11], 32'h0000_0011);
        chk("ret_resume_r10", dut.r[10], 32'h0000_005A);
        chk("ret_squash_r12", dut.r[12], 32'h0);
        chk("cmp_signed_GT", {31'b0, dut.flag_GT}, 32'h1);
        chk("cmp_signed_E", {31'b0, dut.flag_E}, 32'h0);
        chk("alu_pc_parked", 32'(dut.pc >= 32'd15 && dut.pc <= 32'd17), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
